// File: rtl/cache_controller.sv
// cache_controller: write-through, no-write-allocate sequencer between the
// CPU load/store port, a direct-mapped cache array and multi-cycle data memory.
module cache_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     stall,
    output logic [DATA_WIDTH-1:0]    rdata,
    input  logic                     cache_hit,
    input  logic [DATA_WIDTH-1:0]    cache_rdata,
    output logic                     cache_we,
    output logic [DATA_WIDTH-1:0]    cache_wdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

    state_t state;
    state_t state_nx;

    logic hit_inc;
    logic miss_inc;
    logic latch_addr;
    logic latch_wdata;

    // While reset is asserted every output holds its idle value, even
    // though the CPU may still be presenting a request.
    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        rdata       = '0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        latch_addr  = 1'b0;
        latch_wdata = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_we) begin
                            stall       = 1'b1;
                            latch_addr  = 1'b1;
                            latch_wdata = 1'b1;
                            state_nx    = WR_THRU;
                            if (cache_hit) begin
                                cache_we    = 1'b1;
                                cache_wdata = req_wdata;
                            end
                        end else if (cache_hit) begin
                            rdata   = cache_rdata;
                            hit_inc = 1'b1;
                        end else begin
                            stall      = 1'b1;
                            latch_addr = 1'b1;
                            miss_inc   = 1'b1;
                            state_nx   = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ready) begin
                        rdata       = mem_rdata;
                        cache_we    = 1'b1;
                        cache_wdata = mem_rdata;
                        state_nx    = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                WR_THRU: begin
                    if (mem_ready) begin
                        state_nx = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign mem_req = rst && (state != IDLE);
    assign mem_we  = rst && (state == WR_THRU);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nx;
            if (latch_addr) begin
                mem_addr <= req_addr;
            end
            if (latch_wdata) begin
                mem_wdata <= req_wdata;
            end
            // Counters stick at all-ones rather than wrapping.
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed bench with a load-data scoreboard; a second
// instance with 4-bit counters exercises counter saturation.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        stall;
    logic [31:0] rdata;
    logic        cache_we;
    logic [31:0] cache_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        s_stall;
    logic [31:0] s_rdata;
    logic        s_cache_we;
    logic [31:0] s_cache_wdata;
    logic        s_mem_req;
    logic        s_mem_we;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_hit_count;
    logic [3:0]  s_miss_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .cache_we(cache_we), .cache_wdata(cache_wdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(s_stall), .rdata(s_rdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .cache_we(s_cache_we), .cache_wdata(s_cache_wdata),
        .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard whenever a load completes this cycle.
    task automatic score_load(input string tag);
        logic [31:0] exp;
        if (req_valid && !req_we && !stall) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check({tag, "_rdata"}, rdata, exp);
            end
        end
    endtask

    task automatic mem_txn(input string tag, input int waits,
                           input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input int exp_stall);
        int k;
        k = 0;
        while (stall && k < 20) begin
            check({tag, "_rdata_idle"}, rdata, 32'd0);
            k++;
            tick();
            mem_ready = (k > waits);
            mem_rdata = rd;
            #1;
            if (k == 1) begin
                check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
                check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
                check({tag, "_mem_addr"}, mem_addr, addr);
                if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
            end
        end
        check({tag, "_stall_cycles"}, k, exp_stall);
        check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        if (!we) begin
            check({tag, "_fill_we"}, {31'd0, cache_we}, 32'd1);
            check({tag, "_fill_data"}, cache_wdata, rd);
        end else begin
            check({tag, "_wt_cache_we"}, {31'd0, cache_we}, 32'd0);
        end
        score_load(tag);
        tick();
        mem_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h100;
        req_wdata = 32'h0;
        cache_hit = 1'b0;
        cache_rdata = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // Reset held with a request present
        tick();
        tick();
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_cache_we", {31'd0, cache_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Load miss, three memory wait cycles
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h100;
        cache_hit = 1'b0;
        sb_q.push_back(32'hDEADBEEF);
        #1;
        check("ldm_detect_stall", {31'd0, stall}, 32'd1);
        check("ldm_detect_memreq", {31'd0, mem_req}, 32'd0);
        mem_txn("ldm", 3, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 4);
        check("ldm_miss_count", miss_count, 32'd1);

        // Back-to-back load hit
        req_valid = 1'b1;
        req_addr = 32'h100;
        cache_hit = 1'b1;
        cache_rdata = 32'hDEADBEEF;
        sb_q.push_back(32'hDEADBEEF);
        #1;
        check("ldh_stall", {31'd0, stall}, 32'd0);
        check("ldh_mem_req", {31'd0, mem_req}, 32'd0);
        check("ldh_cache_we", {31'd0, cache_we}, 32'd0);
        score_load("ldh");
        tick();
        req_valid = 1'b0;
        #1;
        check("ldh_hit_count", hit_count, 32'd1);
        check("ldh_miss_count", miss_count, 32'd1);

        // Store hit: write-update plus write-through
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h100;
        req_wdata = 32'h12345678;
        cache_hit = 1'b1;
        #1;
        check("sth_cache_we", {31'd0, cache_we}, 32'd1);
        check("sth_cache_wdata", cache_wdata, 32'h12345678);
        check("sth_stall", {31'd0, stall}, 32'd1);
        mem_txn("sth", 1, 1'b1, 32'h100, 32'h12345678, 32'h0, 2);

        // Store miss: memory write only
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h200;
        req_wdata = 32'hCAFEF00D;
        cache_hit = 1'b0;
        #1;
        check("stm_cache_we", {31'd0, cache_we}, 32'd0);
        check("stm_stall", {31'd0, stall}, 32'd1);
        mem_txn("stm", 0, 1'b1, 32'h200, 32'hCAFEF00D, 32'h0, 1);
        #1;
        check("st_hit_count", hit_count, 32'd1);
        check("st_miss_count", miss_count, 32'd1);

        // Reset during a read-miss wait
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h300;
        cache_hit = 1'b0;
        #1;
        check("rmr_detect_stall", {31'd0, stall}, 32'd1);
        tick();
        check("rmr_mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        check("rmr_mem_req_after", {31'd0, mem_req}, 32'd0);
        check("rmr_cache_we", {31'd0, cache_we}, 32'd0);
        check("rmr_stall", {31'd0, stall}, 32'd0);
        check("rmr_rdata", rdata, 32'd0);
        check("rmr_miss_count", miss_count, 32'd0);
        tick();
        mem_ready = 1'b0;

        // Saturation: 4-bit counter instance over 17 hits
        req_valid = 1'b1;
        req_we = 1'b0;
        cache_hit = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            req_addr = 32'h400 + 32'(n * 4);
            cache_rdata = 32'hA5000000 + 32'(n);
            sb_q.push_back(32'hA5000000 + 32'(n));
            #1;
            score_load("sat");
            check("sat_stall", {31'd0, s_stall}, 32'd0);
            tick();
            #1;
            check("sat_cnt4", {28'd0, s_hit_count}, (n > 15) ? 32'd15 : 32'(n));
            check("sat_cnt32", hit_count, 32'(n));
        end
        req_valid = 1'b0;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
